// File: rtl/prbs9_checker.sv
// Self-synchronising serial PRBS9 (x^9 + x^5 + 1) checker with lock detection and BER counters.
// Define PRBS9_CHECKER_ERRLOG_EN to add o_last_err_pos (bit index of the most recent error).
module prbs9_checker #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned WIN_LEN  = 64,
    parameter int unsigned LOSS_ERR = 8
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
`ifdef PRBS9_CHECKER_ERRLOG_EN
    ,
    output logic [CNT_W-1:0] o_last_err_pos
`endif
);

    localparam int unsigned WC = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WE = $clog2(WIN_LEN + 1);

    localparam logic [WC-1:0] WinLast = WC'(WIN_LEN - 1);
    localparam logic [WE-1:0] LossErr = WE'(LOSS_ERR);
    localparam logic [7:0]    LockCnt = 8'(LOCK_CNT);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

    state_e            state_q, state_d;
    logic [8:0]        sr_q, sr_d;
    logic [3:0]        fill_q, fill_d;
    logic [7:0]        good_q, good_d;
    logic [WC-1:0]     win_cnt_q, win_cnt_d;
    logic [WE-1:0]     win_err_q, win_err_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_q, err_d;
`ifdef PRBS9_CHECKER_ERRLOG_EN
    logic [CNT_W-1:0]  pos_q, pos_d;
`endif

    logic              pred;
    logic              mism;
    logic [WE-1:0]     win_total;

    assign pred      = sr_q[8] ^ sr_q[4];
    assign mism      = i_bit ^ pred;
    assign win_total = win_err_q + {{(WE-1){1'b0}}, mism};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        good_d    = good_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
`ifdef PRBS9_CHECKER_ERRLOG_EN
        pos_d     = pos_q;
`endif
        if (i_valid) begin
            unique case (state_q)
                StHunt: begin
                    sr_d = {sr_q[7:0], i_bit};
                    if (fill_q == 4'd8) begin
                        state_d = StVerify;
                        fill_d  = 4'd0;
                        good_d  = 8'd0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                StVerify: begin
                    sr_d = {sr_q[7:0], i_bit};
                    if (mism) begin
                        good_d = 8'd0;
                    end else if (good_q + 8'd1 == LockCnt) begin
                        // All-zero history satisfies the recurrence trivially; keep hunting.
                        if (sr_d != 9'd0) state_d = StLocked;
                        good_d = 8'd0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
                StLocked: begin
                    // Free-run on the prediction so channel errors stay out of the history.
                    sr_d  = {sr_q[7:0], pred};
                    err_d = mism;
                    if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
                    if (mism) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
`ifdef PRBS9_CHECKER_ERRLOG_EN
                        pos_d = bit_cnt_q;
`endif
                    end
                    if (win_total >= LossErr) begin
                        state_d   = StHunt;
                        fill_d    = 4'd0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WinLast) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_total;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
        if (i_clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
`ifdef PRBS9_CHECKER_ERRLOG_EN
            pos_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= StHunt;
            sr_q      <= 9'd0;
            fill_q    <= 4'd0;
            good_q    <= 8'd0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
`ifdef PRBS9_CHECKER_ERRLOG_EN
            pos_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
`ifdef PRBS9_CHECKER_ERRLOG_EN
            pos_q     <= pos_d;
`endif
        end
    end

    assign o_locked    = (state_q == StLocked);
    assign o_err       = err_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;
`ifdef PRBS9_CHECKER_ERRLOG_EN
    assign o_last_err_pos = pos_q;
`endif

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: lock, single/burst errors, lockup, gaps+clear, async reset.
module tb_prbs9_checker;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_clear = 1'b0;
    logic        o_locked;
    logic        o_err;
    logic [31:0] o_bit_count;
    logic [31:0] o_err_count;
`ifdef PRBS9_CHECKER_ERRLOG_EN
    logic [31:0] o_last_err_pos;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int err_pulses = 0;
    int lock_cycles = 0;
    int snap;
    int n_v;
    logic v;
    logic [8:0] gen = 9'b110101010;

    prbs9_checker dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_bit       (i_bit),
        .i_clear     (i_clear),
        .o_locked    (o_locked),
        .o_err       (o_err),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
`ifdef PRBS9_CHECKER_ERRLOG_EN
        ,
        .o_last_err_pos (o_last_err_pos)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_err) err_pulses++;
        if (o_locked) lock_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; valid cycles consume the next generator bit, optionally inverted.
    task automatic step(input logic valid, input logic flip, input logic clr);
        logic b;
        b = 1'b0;
        if (valid) begin
            b   = (gen[8] ^ gen[4]) ^ flip;
            gen = {gen[7:0], gen[8] ^ gen[4]};
        end
        i_valid = valid;
        i_bit   = b;
        i_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_bits", o_bit_count, 32'd0);
        chk("rst_errs", o_err_count, 32'd0);
        i_reset = 1'b0;

        // Clean stream: lock at the 25th bit, then 1000 counted bits
        repeat (24) step(1'b1, 1'b0, 1'b0);
        chk("pre_lock", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("lock_25", {31'd0, o_locked}, 32'd1);
        chk("bits_at_lock", o_bit_count, 32'd0);
        repeat (1000) step(1'b1, 1'b0, 1'b0);
        chk("clean_bits", o_bit_count, 32'd1000);
        chk("clean_errs", o_err_count, 32'd0);
        chk("clean_pulses", err_pulses, 32'd0);

        // Single inverted bit (#100)
        repeat (99) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("single_err_pulse", {31'd0, o_err}, 32'd1);
`ifdef PRBS9_CHECKER_ERRLOG_EN
        chk("last_err_pos", o_last_err_pos, 32'd1099);
`endif
        step(1'b1, 1'b0, 1'b0);
        chk("single_err_drop", {31'd0, o_err}, 32'd0);
        repeat (199) step(1'b1, 1'b0, 1'b0);
        chk("single_errs", o_err_count, 32'd1);
        chk("single_pulses", err_pulses, 32'd1);
        chk("single_locked", {31'd0, o_locked}, 32'd1);
        chk("single_bits", o_bit_count, 32'd1300);

        // Eight errors inside one window force loss of lock
        repeat (7) step(1'b1, 1'b1, 1'b0);
        chk("burst7_locked", {31'd0, o_locked}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("burst8_unlock", {31'd0, o_locked}, 32'd0);
        chk("burst_errs", o_err_count, 32'd9);
        chk("burst_bits", o_bit_count, 32'd1308);
        repeat (24) step(1'b1, 1'b0, 1'b0);
        chk("relock_pre", {31'd0, o_locked}, 32'd0);
        chk("held_bits", o_bit_count, 32'd1308);
        step(1'b1, 1'b0, 1'b0);
        chk("relock_25", {31'd0, o_locked}, 32'd1);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        chk("resume_bits", o_bit_count, 32'd1318);
        chk("resume_errs", o_err_count, 32'd9);

        // All-zero input never locks
        do_reset();
        snap = lock_cycles;
        i_valid = 1'b1;
        i_bit   = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1;
        end
        chk("zero_locked_cycles", lock_cycles - snap, 32'd0);
        chk("zero_bits", o_bit_count, 32'd0);

        // Random valid gaps, clear concurrent with an error
        do_reset();
        n_v = 0;
        while (n_v < 24) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, 1'b0);
            if (v) n_v++;
        end
        chk("gap_pre_lock", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("gap_lock_25", {31'd0, o_locked}, 32'd1);
        repeat (40) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        snap = err_pulses;
        step(1'b1, 1'b1, 1'b1);
        chk("clr_err_pulse", {31'd0, o_err}, 32'd1);
        chk("clr_bits", o_bit_count, 32'd0);
        chk("clr_errs", o_err_count, 32'd0);
`ifdef PRBS9_CHECKER_ERRLOG_EN
        chk("clr_last_pos", o_last_err_pos, 32'd0);
`endif
        step(1'b0, 1'b0, 1'b0);
        chk("gap_err_low", {31'd0, o_err}, 32'd0);
        n_v = 0;
        while (n_v < 10) begin
            v = 1'($urandom_range(0, 1));
            step(v, 1'b0, 1'b0);
            if (v) n_v++;
        end
        chk("post_clr_bits", o_bit_count, 32'd10);
        chk("post_clr_errs", o_err_count, 32'd0);
        chk("clr_pulses", err_pulses - snap, 32'd1);

        // Asynchronous reset between clock edges while locked
        #2 i_reset = 1'b1;
        #1;
        chk("async_locked", {31'd0, o_locked}, 32'd0);
        chk("async_bits", o_bit_count, 32'd0);
        #1 i_reset = 1'b0;
        repeat (24) step(1'b1, 1'b0, 1'b0);
        chk("async_pre_lock", {31'd0, o_locked}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("async_relock", {31'd0, o_locked}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Serial PRBS9 checker (x^9 + x^5 + 1) sitting directly downstream of the PRBS9 generator; consumes its 1-bit output stream, possibly after a channel/loopback.
- Self-synchronises to the incoming sequence, declares lock, then counts received bits and bit errors for BER measurement.
- Detects loss of lock and re-hunts automatically.

Parameters:
- CNT_W, 32, width of bit and error counters (saturating).
- LOCK_CNT, 16, consecutive correct predictions required to declare lock (1..255).
- WIN_LEN, 64, window length in valid bits for loss-of-lock evaluation (power of two, 8..1024).
- LOSS_ERR, 8, errors within one window that force loss of lock (1..WIN_LEN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  qualifies i_bit; when low, no state, counter or shift-register change.
- i_bit  in  1  received PRBS bit.
- i_clear  in  1  synchronous clear of o_bit_count and o_err_count (state/lock unaffected).
- o_locked  out  1  high while in LOCKED.
- o_err  out  1  one-cycle pulse: previous valid bit mismatched (LOCKED only).
- o_bit_count  out  CNT_W  valid bits checked while LOCKED.
- o_err_count  out  CNT_W  mismatches while LOCKED.

Behaviour:
- Reset (async, i_reset=1): state HUNT, 9-bit history sr=0, fill=0, good=0, win_cnt=0, win_err=0; all outputs 0.
- Sequence model: sr[0] newest bit, sr[8] oldest; prediction pred = sr[8] ^ sr[4]; shift is sr <= {sr[7:0], x}.
- All transitions below occur only on cycles with i_valid=1.
- HUNT: x=i_bit; fill increments; after the 9th bit, go to VERIFY with good=0.
- VERIFY (self-sync): x=i_bit.
  - i_bit==pred: good++.
  - mismatch: good=0, stay in VERIFY.
  - When good reaches LOCK_CNT and sr!=0, go to LOCKED. If sr==0 (all-zero lockup), clear good and stay.
- LOCKED (free-run): x=pred, so a channel error does not propagate into the history.
  - Every valid bit: o_bit_count++.
  - Mismatch: o_err_count++, o_err pulses, win_err++.
  - win_cnt counts 0..WIN_LEN-1. The bit that wraps win_cnt belongs to the ending window; afterwards win_err=0.
  - If (win_err + current error) >= LOSS_ERR: go to HUNT next cycle with fill=0, win_cnt=0, win_err=0. sr keeps its content but is refilled from i_bit. Counters hold their values.
- Latency: o_err, o_locked and counters update on the clock edge that samples the bit (visible the following cycle). First lock occurs 9+LOCK_CNT valid bits after the stream starts (25 by default).
- Counters saturate at all-ones; they never wrap.
- i_clear=1 has priority over increments in the same cycle: that cycle's bit is neither counted nor errored, but o_err still pulses. win_cnt/win_err are unaffected.
- i_valid=0 gaps of any length are transparent; o_err is 0 in gap cycles.
- Reset mid-operation: immediate return to reset values regardless of state.

Optional Feature:
- Macro: PRBS9_CHECKER_ERRLOG_EN.
- Defined: adds output o_last_err_pos [CNT_W-1:0], reset 0. On each LOCKED mismatch it loads the o_bit_count value of the errored bit (pre-increment). It is cleared by i_clear and holds otherwise.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Clean stream from generator seeded 9'b110101010, i_valid=1 continuous → o_locked rises after 25th bit; after 1000 further bits o_bit_count=1000, o_err_count=0, o_err never high.
- Locked, invert bit #100 only → single o_err pulse, o_err_count=1, o_locked stays 1, history uncorrupted (no follow-on errors).
- Locked, invert 8 bits within one 64-bit window → o_locked falls after 8th error; relock 25 bits later; counters held then resume.
- All-zero input for 200 bits → never locks, o_bit_count=0.
- Random i_valid (50%) on clean stream with i_clear pulsed concurrent with an injected error → lock at 25th valid bit; counters 0 after clear; o_err pulses once.
- Assert i_reset asynchronously mid-LOCKED, between clock edges → outputs 0 immediately; relock after 25 bits once released.
